// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response codes, VERSION layout, register indices and FSM state types
// shared by the AXI-lite register file.
package axi_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int VER_MAJOR_HI    = 31;
    localparam int VER_MAJOR_LO    = 28;
    localparam int VER_MINOR_HI    = 27;
    localparam int VER_MINOR_LO    = 20;
    localparam int VER_REVISION_HI = 19;
    localparam int VER_REVISION_LO = 16;
    localparam logic [3:0] VER_MAJOR    = 4'd1;
    localparam logic [7:0] VER_MINOR    = 8'd0;
    localparam logic [3:0] VER_REVISION = 4'd0;
    localparam int IDX_VERSION = 0;
    localparam int IDX_STATUS  = 1;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    function automatic logic [31:0] version_word();
        logic [31:0] v;
        v = '0;
        v[VER_MAJOR_HI:VER_MAJOR_LO]       = VER_MAJOR;
        v[VER_MINOR_HI:VER_MINOR_LO]       = VER_MINOR;
        v[VER_REVISION_HI:VER_REVISION_LO] = VER_REVISION;
        return v;
    endfunction
endpackage

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI-lite slave with VERSION, W1C STATUS and NUM_REGS user registers.
// Define AXI_LITE_REGFILE_IRQ_EN to drive o_irq from a registered OR of STATUS.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4
) (
    input  logic                           i_axi_clk,
    input  logic                           i_axi_rst,
    input  logic                           i_awvalid,
    input  logic [ADDR_WIDTH-1:0]          i_awaddr,
    output logic                           o_awready,
    input  logic                           i_wvalid,
    output logic                           o_wready,
    input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    output logic                           o_bvalid,
    input  logic                           i_bready,
    output logic [1:0]                     o_bresp,
    input  logic                           i_arvalid,
    output logic                           o_arready,
    input  logic [ADDR_WIDTH-1:0]          i_araddr,
    output logic                           o_rvalid,
    input  logic                           i_rready,
    output logic [1:0]                     o_rresp,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-1:0]            o_reg_wr_stb,
    input  logic [DATA_WIDTH-1:0]          i_status_set,
    output logic                           o_irq
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [IW-1:0] IDX_LIMIT = IW'(NUM_REGS + 2);

    w_state_t              w_state, w_next;
    r_state_t              r_state, r_next;
    logic [IW-1:0]         aw_idx_q, wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wdata_q, wr_data, wr_mask, rd_val, status, st_clr;
    logic [SW-1:0]         wstrb_q, wr_strb;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  aw_hs, w_hs, ar_hs, commit, unused_addr_bits;

    assign o_awready = (w_state == W_IDLE) || (w_state == W_HAVE_DATA);
    assign o_wready  = (w_state == W_IDLE) || (w_state == W_HAVE_ADDR);
    assign o_bvalid  = w_state == W_RESP;
    assign o_arready = r_state == R_IDLE;
    assign o_rvalid  = r_state == R_RESP;
    assign aw_hs     = i_awvalid && o_awready;
    assign w_hs      = i_wvalid && o_wready;
    assign ar_hs     = i_arvalid && o_arready;
    // The second of the two handshakes commits; the first one is replayed from its holding register.
    assign commit    = (aw_hs || w_state == W_HAVE_ADDR) && (w_hs || w_state == W_HAVE_DATA);
    assign wr_idx    = (w_state == W_HAVE_ADDR) ? aw_idx_q : i_awaddr[ADDR_WIDTH-1:2];
    assign wr_data   = (w_state == W_HAVE_DATA) ? wdata_q : i_wdata;
    assign wr_strb   = (w_state == W_HAVE_DATA) ? wstrb_q : i_wstrb;
    assign rd_idx    = i_araddr[ADDR_WIDTH-1:2];
    assign st_clr    = (commit && wr_idx == IW'(IDX_STATUS)) ? (wr_data & wr_mask) : '0;
    assign unused_addr_bits = ^{i_awaddr[1:0], i_araddr[1:0]};

    always_comb begin
        for (int b = 0; b < SW; b++)
            wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
    end

    always_comb begin
        rd_val = '0;
        if (rd_idx == IW'(IDX_VERSION)) rd_val = DATA_WIDTH'(version_word());
        if (rd_idx == IW'(IDX_STATUS)) rd_val = status;
        for (int k = 0; k < NUM_REGS; k++)
            if (rd_idx == IW'(k + 2)) rd_val = regs[k];
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:      w_next = (aw_hs && w_hs) ? W_RESP : aw_hs ? W_HAVE_ADDR : w_hs ? W_HAVE_DATA : W_IDLE;
            W_HAVE_ADDR: w_next = w_hs ? W_RESP : W_HAVE_ADDR;
            W_HAVE_DATA: w_next = aw_hs ? W_RESP : W_HAVE_DATA;
            W_RESP:      w_next = i_bready ? W_IDLE : W_RESP;
            default:     w_next = W_IDLE;
        endcase
        r_next = (r_state == R_IDLE) ? (ar_hs ? R_RESP : R_IDLE) : (i_rready ? R_IDLE : R_RESP);
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst) begin
            w_state      <= W_IDLE;
            r_state      <= R_IDLE;
            aw_idx_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            o_bresp      <= RESP_OKAY;
            o_rresp      <= RESP_OKAY;
            o_rdata      <= '0;
            o_reg_wr_stb <= '0;
            status       <= '0;
            for (int k = 0; k < NUM_REGS; k++)
                regs[k] <= '0;
        end else begin
            w_state      <= w_next;
            r_state      <= r_next;
            o_reg_wr_stb <= '0;
            // Clear first, then OR in new events so a simultaneous set survives the W1C.
            status       <= (status & ~st_clr) | i_status_set;
            if (aw_hs)
                aw_idx_q <= i_awaddr[ADDR_WIDTH-1:2];
            if (w_hs) begin
                wdata_q <= i_wdata;
                wstrb_q <= i_wstrb;
            end
            if (commit)
                o_bresp <= (wr_idx < IDX_LIMIT) ? RESP_OKAY : RESP_SLVERR;
            for (int k = 0; k < NUM_REGS; k++)
                if (commit && wr_idx == IW'(k + 2)) begin
                    regs[k]         <= (regs[k] & ~wr_mask) | (wr_data & wr_mask);
                    o_reg_wr_stb[k] <= 1'b1;
                end
            if (ar_hs) begin
                o_rdata <= rd_val;
                o_rresp <= (rd_idx < IDX_LIMIT) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

`ifdef AXI_LITE_REGFILE_IRQ_EN
    logic irq_q;
    always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
        if (!i_axi_rst)
            irq_q <= 1'b0;
        else
            irq_q <= |status;
    end
    assign o_irq = irq_q;
`else
    assign o_irq = 1'b0;
`endif
endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb_axi_lite_regfile: directed stimulus with B/R response scoreboards for axi_lite_regfile.
`timescale 1ns/1ps
module tb_axi_lite_regfile;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 4;
`ifdef AXI_LITE_REGFILE_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [AW-1:0]    awaddr = '0, araddr = '0;
    logic [DW-1:0]    wdata = '0, status_set = '0;
    logic [DW/8-1:0]  wstrb = '0;
    logic             awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]       bresp, rresp;
    logic [DW-1:0]    rdata;
    logic [NR*DW-1:0] regs;
    logic [NR-1:0]    reg_wr_stb;

    typedef struct packed {logic [1:0] resp; logic [DW-1:0] data;} rexp_t;
    logic [1:0] bq[$];
    rexp_t      rq[$];
    rexp_t      r_exp;
    int         n_checks = 0, n_fail = 0, n_bheld = 0, n_awlow = 0;

    axi_lite_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .i_axi_clk(clk), .i_axi_rst(rst_n),
        .i_awvalid(awvalid), .i_awaddr(awaddr), .o_awready(awready),
        .i_wvalid(wvalid), .o_wready(wready), .i_wstrb(wstrb), .i_wdata(wdata),
        .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
        .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr),
        .o_rvalid(rvalid), .i_rready(rready), .o_rresp(rresp), .o_rdata(rdata),
        .o_regs(regs), .o_reg_wr_stb(reg_wr_stb), .i_status_set(status_set), .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout, expected handshake", name);
    endtask

    // Response monitor: pops the scoreboard whenever a B or R handshake is about to happen.
    initial forever begin
        @(negedge clk);
        if (rst_n && bvalid && bready) begin
            if (bq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL bresp_unexpected: got 0x%0h, expected no response", bresp);
            end else
                check("bresp", bresp, bq.pop_front());
        end
        if (rst_n && rvalid && rready) begin
            if (rq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rresp_unexpected: got 0x%0h, expected no response", rresp);
            end else begin
                r_exp = rq.pop_front();
                check("rresp", rresp, r_exp.resp);
                check("rdata", rdata, r_exp.data);
            end
        end
    end

    task automatic aw_send(input logic [AW-1:0] a, input int dly);
        bit hs = 0;
        repeat (dly) begin @(posedge clk); #1; end
        awvalid = 1'b1;
        awaddr  = a;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk); hs = awready;
            @(posedge clk); #1;
        end
        awvalid = 1'b0;
        if (!hs) timeout("aw_handshake");
    endtask

    task automatic w_send(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input int dly);
        bit hs = 0;
        repeat (dly) begin @(posedge clk); #1; end
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk); hs = wready;
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        if (!hs) timeout("w_handshake");
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                         input int aw_dly, input int w_dly, input logic [1:0] resp, input logic [NR-1:0] stb);
        bq.push_back(resp);
        fork
            aw_send(a, aw_dly);
            w_send(d, s, w_dly);
        join
        check("wr_stb_pulse", reg_wr_stb, stb);
        check("bvalid_after_commit", bvalid, 1'b1);
        @(posedge clk); #1;
        check("wr_stb_clear", reg_wr_stb, '0);
    endtask

    task automatic read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] resp);
        bit hs = 0;
        rq.push_back(rexp_t'{resp: resp, data: d});
        arvalid = 1'b1;
        araddr  = a;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk); hs = arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        if (!hs) timeout("ar_handshake");
        else check("rvalid_one_cycle_after_ar", rvalid, 1'b1);
        @(posedge clk); #1;
        check("rvalid_clear", rvalid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", {bvalid, rvalid, bresp, rresp, reg_wr_stb, irq}, '0);
        check("reset_rdata", rdata, '0);
        check("reset_regs", regs, '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", {awready, wready, arready}, 3'b111);

        read(32'h00, 32'h1000_0000, 2'b00);
        write(32'h08, 32'hDEAD_BEEF, 4'hF, 3, 0, 2'b00, 4'b0001);
        check("regs_w_before_aw", regs, {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF});
        write(32'h08, 32'h0000_0011, 4'h1, 0, 0, 2'b00, 4'b0001);
        check("regs_byte_strobe", regs[31:0], 32'hDEAD_BE11);
        read(32'h0B, 32'hDEAD_BE11, 2'b00);
        write(32'h14, 32'h1234_5678, 4'hC, 0, 2, 2'b00, 4'b1000);
        read(32'h14, 32'h1234_0000, 2'b00);
        write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10, 4'b0000);
        check("regs_after_slverr", regs, {32'h1234_0000, 32'h0, 32'h0, 32'hDEAD_BE11});
        read(32'h40, 32'h0, 2'b10);
        write(32'h18, 32'hFFFF_FFFF, 4'hF, 1, 0, 2'b10, 4'b0000);
        read(32'h18, 32'h0, 2'b10);
        write(32'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00, 4'b0000);
        read(32'h00, 32'h1000_0000, 2'b00);
        check("regs_after_version_write", regs, {32'h1234_0000, 32'h0, 32'h0, 32'hDEAD_BE11});

        fork
            write(32'h0C, 32'hA5A5_A5A5, 4'hF, 0, 0, 2'b00, 4'b0010);
            read(32'h0C, 32'h0, 2'b00);
        join
        read(32'h0C, 32'hA5A5_A5A5, 2'b00);

        status_set = 32'h5;
        @(posedge clk); #1;
        status_set = '0;
        @(posedge clk); #1;
        check("irq_after_set", irq, IRQ_ON);
        read(32'h04, 32'h5, 2'b00);
        fork
            write(32'h04, 32'h4, 4'hF, 0, 0, 2'b00, 4'b0000);
            begin
                status_set = 32'h4;
                @(posedge clk); #1;
                status_set = '0;
            end
        join
        read(32'h04, 32'h5, 2'b00);
        check("irq_set_wins", irq, IRQ_ON);
        write(32'h04, 32'h5, 4'hF, 0, 0, 2'b00, 4'b0000);
        check("irq_after_clear", irq, 1'b0);
        read(32'h04, 32'h0, 2'b00);

        bready = 1'b0;
        write(32'h10, 32'h0BAD_F00D, 4'hF, 0, 0, 2'b00, 4'b0100);
        check("regs_before_reset", regs, {32'h1234_0000, 32'h0BAD_F00D, 32'hA5A5_A5A5, 32'hDEAD_BE11});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bvalid) n_bheld++;
            if (!awready && !wready) n_awlow++;
        end
        check("bvalid_held_cycles", n_bheld, 10);
        check("aw_w_blocked_cycles", n_awlow, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("bvalid_async_reset", bvalid, 1'b0);
        check("regs_async_reset", regs, '0);
        check("stb_irq_async_reset", {reg_wr_stb, irq}, '0);
        bq.delete();
        @(negedge clk); rst_n = 1'b1;
        bready = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rerelease", {awready, wready, arready}, 3'b111);

        w_send(32'hCAFE_F00D, 4'hF, 0);
        #2;
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("dropped_txn_no_resp", bvalid, 1'b0);
        check("dropped_txn_regs", regs, '0);
        read(32'h08, 32'h0, 2'b00);

        repeat (3) @(posedge clk);
        check("b_scoreboard_drained", bq.size(), 0);
        check("r_scoreboard_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI-lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values are 32 and 64.
REQ-003 SHALL have parameter NUM_REGS, default 4, number of user read/write registers; legal range is 1..64.
REQ-004 SHALL have ports: i_axi_clk in 1, sole clock; i_axi_rst in 1, reset, asynchronous and active-low.
REQ-005 SHALL have write address channel ports: i_awvalid in 1; i_awaddr in ADDR_WIDTH; o_awready out 1.
REQ-006 SHALL have write data channel ports: i_wvalid in 1; o_wready out 1; i_wstrb in DATA_WIDTH/8; i_wdata in DATA_WIDTH.
REQ-007 SHALL have write response channel ports: o_bvalid out 1; i_bready in 1; o_bresp out 2.
REQ-008 SHALL have read channel ports: i_arvalid in 1; o_arready out 1; i_araddr in ADDR_WIDTH; o_rvalid out 1; i_rready in 1; o_rresp out 2; o_rdata out DATA_WIDTH.
REQ-009 SHALL have user ports: o_regs out NUM_REGS*DATA_WIDTH, flat user registers with register k at bits [k*DATA_WIDTH +: DATA_WIDTH]; o_reg_wr_stb out NUM_REGS, one-cycle write pulse per register; i_status_set in DATA_WIDTH, sticky status set bits; o_irq out 1, interrupt.

Function
REQ-010 SHALL use register index addr[ADDR_WIDTH-1:2] and ignore addr[1:0]; the map is 0 = VERSION (RO), 1 = STATUS (W1C), 2..NUM_REGS+1 = user register k = index-2.
REQ-011 SHALL implement a write FSM with states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA and W_RESP.
REQ-012 In the write FSM, o_awready SHALL be high in W_IDLE and W_HAVE_DATA, and o_wready SHALL be high in W_IDLE and W_HAVE_ADDR.
REQ-013 AW and W SHALL be accepted in either order or in the same cycle, and the transaction SHALL commit on the edge completing the second handshake, after which the FSM enters W_RESP.
REQ-014 At commit, a user register SHALL update only the bytes whose i_wstrb bit is set, and o_reg_wr_stb[k] SHALL pulse for the one cycle following commit.
REQ-015 At commit, a STATUS write SHALL clear each bit where wdata=1 and its byte strobe is set.
REQ-016 In W_RESP, o_bvalid SHALL be 1 and hold until i_bready=1, then the FSM SHALL return to W_IDLE; no new AW or W is accepted while in W_RESP.
REQ-017 SHALL implement a read FSM with states R_IDLE (o_arready=1) and R_RESP (o_rvalid=1).
REQ-018 On the AR handshake edge, the block SHALL register o_rdata and o_rresp and enter R_RESP; o_rvalid SHALL assert the cycle after the handshake, hold o_rdata stable, and clear on i_rready=1.
REQ-019 The read and write FSMs SHALL operate concurrently; a read handshaking on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-020 An index > NUM_REGS+1 SHALL produce SLVERR (2'b10), discard the write, and read as 0; every other access SHALL respond OKAY (2'b00).
REQ-021 A write to VERSION SHALL respond OKAY, be ignored, and produce no strobe.
REQ-022 STATUS SHALL set its bits each cycle from i_status_set | current value, and a set SHALL win over a simultaneous W1C on the same bit.
REQ-023 VERSION SHALL read {MAJOR[31:28], MINOR[27:20], REVISION[19:16], 16'h0}, zero-extended when DATA_WIDTH=64.

Reset
REQ-024 Asserting i_axi_rst low SHALL immediately, and independently of the clock, force both FSMs to idle, o_bvalid=0, o_rvalid=0, o_bresp=0, o_rresp=0, o_rdata=0, o_regs=0, o_reg_wr_stb=0, STATUS=0 and o_irq=0.
REQ-025 Reset asserted mid-transaction SHALL drop that transaction with no response and no register update.
REQ-026 Deassertion of reset SHALL be synchronous to i_axi_clk, and o_awready, o_wready and o_arready SHALL be 1 on the first clock after release.

Configuration
REQ-027 SHALL support macro AXI_LITE_REGFILE_IRQ_EN.
REQ-028 With AXI_LITE_REGFILE_IRQ_EN defined, o_irq SHALL be a registered |STATUS, asserted one cycle after any STATUS bit becomes 1.
REQ-029 Without AXI_LITE_REGFILE_IRQ_EN, o_irq SHALL be tied 0; STATUS SHALL behave identically either way.

Structure
REQ-030 The shared package axi_lite_pkg SHALL hold: RESP_OKAY/RESP_SLVERR constants, the VERSION field ranges and values, the register index constants IDX_VERSION and IDX_STATUS, and the write/read FSM state typedefs.
REQ-031 The block SHALL have no sub-module; it SHALL be a single flat module.

Verification
REQ-032 The bench SHALL cover: read idx0 -> rdata=0x10000000, rresp=0, with rvalid one cycle after the AR handshake.
REQ-033 The bench SHALL cover: W before AW by 3 cycles, addr 0x08, data 0xDEADBEEF, strb 0xF -> o_regs[31:0]=0xDEADBEEF, o_reg_wr_stb=0001 for one cycle, bresp=0.
REQ-034 The bench SHALL cover: user reg0=0xDEADBEEF, write addr 0x08 data 0x00000011 strb 0x1 -> reg0=0xDEADBE11.
REQ-035 The bench SHALL cover: NUM_REGS=4, write and read addr 0x40 -> bresp=2'b10, rresp=2'b10, rdata=0, o_regs unchanged.
REQ-036 The bench SHALL cover, with IRQ_EN: i_status_set=0x5 for one pulse -> STATUS=0x5 and o_irq=1; write 0x4 to addr 0x04 in the same cycle as i_status_set=0x4 -> STATUS stays 0x5; write 0x5 -> STATUS=0 and o_irq=0.
REQ-037 The bench SHALL cover: i_bready held low for 10 cycles -> o_bvalid held, o_awready=0 throughout; i_axi_rst low mid-hold -> o_bvalid=0 immediately, o_regs=0.
